// File: rtl/alu_seq_pkg.sv
// Shared ALU select codes and sequencer state encoding for alu_sequencer.
package alu_seq_pkg;

  localparam logic [7:0] ALU_SEL_NOP = 8'd0;
  localparam logic [7:0] ALU_SEL_ADD = 8'd11;
  localparam logic [7:0] ALU_SEL_SUB = 8'd100;
  localparam logic [7:0] ALU_SEL_DIV = 8'd110;
  localparam logic [7:0] ALU_SEL_MOD = 8'd111;
  localparam logic [7:0] ALU_SEL_CMP = 8'd24;

  typedef enum logic [0:0] {
    SEQ_IDLE  = 1'b0,
    SEQ_ISSUE = 1'b1
  } seq_state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// Architectural register file: one write port, two read ports captured on command
// accept (operand 2 optionally replaced by an immediate), and a combinational debug port.
module alu_seq_regfile #(
  parameter int REG_COUNT = 4,
  parameter int AW        = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          cap_en,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  input  logic          use_imm,
  input  logic [7:0]    imm,
  output logic [7:0]    rd_q1,
  output logic [7:0]    rd_q2,
  output logic [7:0]    op2_next,
  input  logic [AW-1:0] dbg_addr,
  output logic [7:0]    dbg_data
);

  logic [7:0] mem [REG_COUNT];

  // op2_next is exposed so the top can inspect the operand before it is committed
  assign op2_next = use_imm ? imm : mem[rd_addr2];
  assign dbg_data = mem[dbg_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        mem[i] <= 8'd0;
      end
      rd_q1 <= 8'd0;
      rd_q2 <= 8'd0;
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      if (cap_en) begin
        rd_q1 <= mem[rd_addr1];
        rd_q2 <= op2_next;
      end
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Execute-stage controller: accepts one command, holds ALU inputs for SETTLE_CYCLES, then
// captures result/flags/compare. Optional ALU_SEQ_DIVZERO_TRAP_EN suppresses DIV/MOD by zero.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int REG_COUNT     = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [7:0]                   cmd_op,
  input  logic [$clog2(REG_COUNT)-1:0] cmd_dst,
  input  logic [$clog2(REG_COUNT)-1:0] cmd_src1,
  input  logic [$clog2(REG_COUNT)-1:0] cmd_src2,
  input  logic                         cmd_use_imm,
  input  logic [7:0]                   cmd_imm,
  output logic [7:0]                   alu_operand1,
  output logic [7:0]                   alu_operand2,
  output logic [7:0]                   alu_sel,
  input  logic [7:0]                   alu_result,
  input  logic [6:0]                   alu_flags,
  input  logic                         alu_eq,
  input  logic                         alu_gt,
  input  logic                         alu_lt,
  output logic [6:0]                   flags_q,
  output logic [2:0]                   cmp_q,
  output logic                         done,
  output logic                         trap,
  input  logic [$clog2(REG_COUNT)-1:0] dbg_addr,
  output logic [7:0]                   dbg_data
);

  // state | meaning
  // IDLE  | ready for a command, ALU inputs parked at NOP / zero
  // ISSUE | ALU inputs held from the latched command while the settle counter runs

  localparam int         AW       = $clog2(REG_COUNT);
  localparam logic [0:0] IDLE     = SEQ_IDLE;
  localparam logic [0:0] ISSUE    = SEQ_ISSUE;
  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

`ifdef ALU_SEQ_DIVZERO_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  logic [0:0]    state_q;
  logic [3:0]    cnt_q;
  logic [7:0]    op_q;
  logic [AW-1:0] dst_q;
  logic [7:0]    opnd1_q;
  logic [7:0]    opnd2_q;
  logic [7:0]    opnd2_next;
  logic          issuing;
  logic          accept;
  logic          div_zero;
  logic          capture;
  logic          reg_we;

  assign issuing   = (state_q == ISSUE);
  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign div_zero  = TRAP_EN & accept & (opnd2_next == 8'd0) &
                     ((cmd_op == ALU_SEL_DIV) | (cmd_op == ALU_SEL_MOD));
  assign capture   = issuing & (cnt_q == LAST_CNT);
  assign reg_we    = capture & (op_q != ALU_SEL_CMP);

  assign alu_sel      = issuing ? op_q    : ALU_SEL_NOP;
  assign alu_operand1 = issuing ? opnd1_q : 8'd0;
  assign alu_operand2 = issuing ? opnd2_q : 8'd0;

  // Operands are snapshotted at accept, so dst == src never sees its own write.
  alu_seq_regfile #(
    .REG_COUNT (REG_COUNT),
    .AW        (AW)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (reg_we),
    .waddr    (dst_q),
    .wdata    (alu_result),
    .cap_en   (accept),
    .rd_addr1 (cmd_src1),
    .rd_addr2 (cmd_src2),
    .use_imm  (cmd_use_imm),
    .imm      (cmd_imm),
    .rd_q1    (opnd1_q),
    .rd_q2    (opnd2_q),
    .op2_next (opnd2_next),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= ALU_SEL_NOP;
      dst_q   <= '0;
      flags_q <= 7'd0;
      cmp_q   <= 3'd0;
      done    <= 1'b0;
      trap    <= 1'b0;
    end else begin
      done <= 1'b0;
      trap <= div_zero;
      case (state_q)
        IDLE: begin
          if (accept && !div_zero) begin
            op_q    <= cmd_op;
            dst_q   <= cmd_dst;
            cnt_q   <= 4'd0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q <= cnt_q + 4'd1;
          if (capture) begin
            flags_q <= alu_flags;
            if (op_q == ALU_SEL_CMP) begin
              cmp_q <= {alu_lt, alu_gt, alu_eq};
            end
            done    <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU plus a register-file reference model.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int REG_COUNT = 4;
  localparam int SETTLE    = 2;
  localparam int AW        = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_op;
  logic [AW-1:0] cmd_dst, cmd_src1, cmd_src2, dbg_addr;
  logic          cmd_use_imm;
  logic [7:0]    cmd_imm;
  logic [7:0]    alu_operand1, alu_operand2, alu_sel, alu_result, dbg_data;
  logic [6:0]    alu_flags, flags_q;
  logic          alu_eq, alu_gt, alu_lt;
  logic [2:0]    cmp_q;
  logic          done, trap;

  int errors = 0;
  int checks = 0;

  logic [7:0] ref_regs [REG_COUNT];
  logic [6:0] ref_flags;
  logic [2:0] ref_cmp;

  alu_sequencer #(.REG_COUNT(REG_COUNT), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
    .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .alu_eq(alu_eq), .alu_gt(alu_gt), .alu_lt(alu_lt),
    .flags_q(flags_q), .cmp_q(cmp_q), .done(done), .trap(trap),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_res(input logic [7:0] sel, input logic [7:0] a, input logic [7:0] b);
    case (sel)
      ALU_SEL_ADD:              return a + b;
      ALU_SEL_SUB, ALU_SEL_CMP: return a - b;
      ALU_SEL_DIV:              return (b == 8'd0) ? 8'hFF : a / b;
      ALU_SEL_MOD:              return (b == 8'd0) ? a : a % b;
      default:                  return 8'd0;
    endcase
  endfunction

  // flags: [0] zero, [1] carry/borrow, [2] negative, [3] operand2 zero
  function automatic logic [6:0] m_flg(input logic [7:0] sel, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic       c;
    r = m_res(sel, a, b);
    if (sel == ALU_SEL_ADD)                           c = (int'(a) + int'(b)) > 255;
    else if (sel == ALU_SEL_SUB || sel == ALU_SEL_CMP) c = (a < b);
    else                                               c = 1'b0;
    return {3'b000, (b == 8'd0), r[7], c, (r == 8'd0)};
  endfunction

  always_comb begin
    alu_result = m_res(alu_sel, alu_operand1, alu_operand2);
    alu_flags  = m_flg(alu_sel, alu_operand1, alu_operand2);
    alu_eq     = (alu_operand1 == alu_operand2);
    alu_gt     = (alu_operand1 >  alu_operand2);
    alu_lt     = (alu_operand1 <  alu_operand2);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < REG_COUNT; i++) begin
      dbg_addr = AW'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), 32'(dbg_data), 32'(ref_regs[i]));
    end
  endtask

  task automatic clear_ref();
    for (int i = 0; i < REG_COUNT; i++) ref_regs[i] = 8'd0;
    ref_flags = 7'd0;
    ref_cmp   = 3'd0;
  endtask

  task automatic drive_cmd(input logic [7:0] op, input int dst, input int s1, input int s2,
                           input int ui, input int imm);
    cmd_op      = op;
    cmd_dst     = AW'(dst);
    cmd_src1    = AW'(s1);
    cmd_src2    = AW'(s2);
    cmd_use_imm = (ui != 0);
    cmd_imm     = 8'(imm);
    cmd_valid   = 1'b1;
  endtask

  // Entered one step after the accept edge; returns one step after the capture edge.
  task automatic expect_issue(input logic [7:0] op, input int dst, input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < SETTLE; i++) begin
      chk("issue_ready", 32'(cmd_ready), 32'd0);
      chk("issue_sel",   32'(alu_sel), 32'(op));
      chk("issue_op1",   32'(alu_operand1), 32'(a));
      chk("issue_op2",   32'(alu_operand2), 32'(b));
      chk("issue_done",  32'(done), 32'd0);
      if (i == SETTLE - 1) begin
        dbg_addr = AW'(dst);
        #1;
        chk("dbg_old", 32'(dbg_data), 32'(ref_regs[dst]));
      end
      @(posedge clk); #1;
    end
    if (op != ALU_SEL_CMP) ref_regs[dst] = m_res(op, a, b);
    else                   ref_cmp = {a < b, a > b, a == b};
    ref_flags = m_flg(op, a, b);
    chk("retire_done",  32'(done), 32'd1);
    chk("retire_ready", 32'(cmd_ready), 32'd1);
    chk("retire_sel",   32'(alu_sel), 32'(ALU_SEL_NOP));
    chk("retire_flags", 32'(flags_q), 32'(ref_flags));
    chk("retire_cmp",   32'(cmp_q), 32'(ref_cmp));
    dbg_addr = AW'(dst);
    #1;
    chk("dbg_new", 32'(dbg_data), 32'(ref_regs[dst]));
  endtask

  task automatic run_cmd(input logic [7:0] op, input int dst, input int s1, input int s2,
                         input int ui, input int imm);
    logic [7:0] a, b;
    a = ref_regs[s1];
    b = (ui != 0) ? 8'(imm) : ref_regs[s2];
    drive_cmd(op, dst, s1, s2, ui, imm);
    chk("accept_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
    if ((op == ALU_SEL_DIV || op == ALU_SEL_MOD) && b == 8'd0) begin
      chk("trap_pulse", 32'(trap), 32'd1);
      chk("trap_done",  32'(done), 32'd0);
      chk("trap_ready", 32'(cmd_ready), 32'd1);
      chk("trap_sel",   32'(alu_sel), 32'(ALU_SEL_NOP));
      chk("trap_flags", 32'(flags_q), 32'(ref_flags));
      chk("trap_cmp",   32'(cmp_q), 32'(ref_cmp));
      check_regs("trap");
      @(posedge clk); #1;
      chk("trap_clear", 32'(trap), 32'd0);
      chk("trap_nodone", 32'(done), 32'd0);
    end else
`endif
    begin
      expect_issue(op, dst, a, b);
      chk("retire_trap", 32'(trap), 32'd0);
      @(posedge clk); #1;
      chk("done_clear", 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] a, b;
    logic [7:0] ops [5];
    ops[0] = ALU_SEL_ADD; ops[1] = ALU_SEL_SUB; ops[2] = ALU_SEL_DIV;
    ops[3] = ALU_SEL_MOD; ops[4] = ALU_SEL_CMP;

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 8'd0; cmd_dst = '0; cmd_src1 = '0;
    cmd_src2 = '0; cmd_use_imm = 1'b0; cmd_imm = 8'd0; dbg_addr = '0;
    clear_ref();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_sel",   32'(alu_sel), 32'd0);
    chk("rst_op1",   32'(alu_operand1), 32'd0);
    chk("rst_op2",   32'(alu_operand2), 32'd0);
    chk("rst_flags", 32'(flags_q), 32'd0);
    chk("rst_cmp",   32'(cmp_q), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_trap",  32'(trap), 32'd0);
    check_regs("rst");
    @(posedge clk); #1;

    // ADD r1 = r0 + 5
    run_cmd(ALU_SEL_ADD, 1, 0, 0, 1, 5);
    chk("t1_r1", 32'(ref_regs[1]), 32'd5);
    // r2 = 7, then r3 = r1 + r2
    run_cmd(ALU_SEL_ADD, 2, 0, 0, 1, 7);
    run_cmd(ALU_SEL_ADD, 3, 1, 2, 0, 0);
    check_regs("t2");
    chk("t2_zero_flag", 32'(flags_q[0]), 32'd0);
    // CMP r1, r2: no register write
    run_cmd(ALU_SEL_CMP, 3, 1, 2, 0, 0);
    check_regs("t3");
    // DIV r1 by immediate zero
    run_cmd(ALU_SEL_DIV, 1, 1, 0, 1, 0);
    check_regs("t4");

    // Back-to-back with cmd_valid held: second accepted at E0+SETTLE+1
    a = ref_regs[1];
    drive_cmd(ALU_SEL_ADD, 2, 1, 0, 1, 3);
    @(posedge clk); #1;
    drive_cmd(ALU_SEL_SUB, 3, 2, 1, 0, 0);
    expect_issue(ALU_SEL_ADD, 2, a, 8'd3);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("b2b_accepted", 32'(cmd_ready), 32'd0);
    a = ref_regs[2];
    b = ref_regs[1];
    expect_issue(ALU_SEL_SUB, 3, a, b);
    @(posedge clk); #1;
    chk("b2b_done_clear", 32'(done), 32'd0);
    check_regs("b2b");

    // Reset during the second ISSUE cycle of a write to r2
    drive_cmd(ALU_SEL_ADD, 2, 0, 0, 1, 9);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_ref();
    chk("rsti_done",  32'(done), 32'd0);
    chk("rsti_ready", 32'(cmd_ready), 32'd1);
    chk("rsti_flags", 32'(flags_q), 32'd0);
    chk("rsti_cmp",   32'(cmp_q), 32'd0);
    check_regs("rsti");
    @(posedge clk); #1;
    chk("rsti_done2", 32'(done), 32'd0);

    // Reset coinciding with an accept: reset wins
    drive_cmd(ALU_SEL_ADD, 1, 0, 0, 1, 4);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    cmd_valid = 1'b0;
    chk("rsta_ready", 32'(cmd_ready), 32'd1);
    chk("rsta_sel",   32'(alu_sel), 32'd0);
    @(posedge clk); #1;
    chk("rsta_done",  32'(done), 32'd0);
    check_regs("rsta");

    // Randomized commands against the reference model
    for (int n = 0; n < 40; n++) begin
      int imm;
      imm = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
      run_cmd(ops[$urandom_range(0, 4)], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), imm);
    end
    check_regs("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Execute-stage controller that drives the ALU as its initiator. It accepts one command at a time over a valid/ready handshake and reads the operands from a small internal register file. It holds `alu_sel` and the operands stable for a fixed settle window, then captures the ALU result, flags and compare outputs into architectural state. It sits between the instruction decoder (upstream) and the combinational ALU (downstream).

## Interface
Parameters:
- `REG_COUNT`, default 4: register-file entries; the address width is `$clog2(REG_COUNT)`.
- `SETTLE_CYCLES`, default 2 (legal 1..15): cycles the ALU inputs are held before capture.

Ports:
- `clk`, in, 1: single clock; everything is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: sequencer idle; high only in IDLE.
- `cmd_op`, in, 8: ALU select code, using the package constants.
- `cmd_dst`, `cmd_src1`, `cmd_src2`, in, AW each: register addresses.
- `cmd_use_imm`, in, 1: when 1, operand2 comes from `cmd_imm` instead of `reg[cmd_src2]`.
- `cmd_imm`, in, 8: immediate operand.
- `alu_operand1`, `alu_operand2`, out, 8: to the ALU.
- `alu_sel`, out, 8: to the ALU.
- `alu_result`, in, 8: from the ALU.
- `alu_flags`, in, 7: from the ALU.
- `alu_eq`, `alu_gt`, `alu_lt`, in, 1 each: from the ALU.
- `flags_q`, out, 7: registered flags of the last executed op.
- `cmp_q`, out, 3: `{lt,gt,eq}` from the last CMP.
- `done`, out, 1: one-cycle pulse when a command retires.
- `trap`, out, 1: one-cycle pulse on a suppressed op (see Configuration).
- `dbg_addr`, in, AW; `dbg_data`, out, 8: combinational register-file read.

## Operation
FSM states: IDLE, ISSUE.

IDLE:
- `cmd_ready`=1; `alu_sel`=`ALU_SEL_NOP` (8'd0); operands = 0.
- On `cmd_valid & cmd_ready`: latch op/dst/imm and the two operand values read from the register file at that edge; clear the settle counter; go to ISSUE.

ISSUE:
- `cmd_ready`=0.
- `alu_sel` and the operands are driven from the latched copies and are constant for the whole state.
- The counter increments each cycle. On the edge where counter == `SETTLE_CYCLES`-1, capture and go to IDLE.

Capture:
- Non-CMP: `reg[dst]`←`alu_result`; `flags_q`←`alu_flags`; `cmp_q` holds.
- CMP: no register write; `flags_q`←`alu_flags`; `cmp_q`←`{alu_lt,alu_gt,alu_eq}`.
- `done`=1 in the cycle after the capture edge.

Other rules:
- Operand-1-only ops (INC, DEC, NOT, SL, SR, ROL, ROR) still drive operand2 from src2/imm; the value is don't-care to the ALU.
- `cmd_valid` while busy is ignored. The command must be held until `cmd_ready`.
- `dst`==`src`: the operand is captured at accept, so there is no hazard.
- `dbg_data` shows the old value up to and including the capture edge, and the new value afterwards.
- All arithmetic is 8-bit; the sequencer does no arithmetic of its own.

## Timing
- Reset values: `cmd_ready`=1, `alu_sel`=0, operands=0, all registers=0, `flags_q`=7'b0, `cmp_q`=3'b0, `done`=0, `trap`=0.
- Command accepted at edge E0. The capture edge is E0+`SETTLE_CYCLES`. `done` and `cmd_ready` are high in the following cycle.
- The next accept can occur at E0+`SETTLE_CYCLES`+1. Throughput is one command per `SETTLE_CYCLES`+1 cycles.
- Reset in ISSUE: return to IDLE, clear everything, no write, no `done`.
- Reset on the same edge as an accept: reset wins.

## Configuration
`ALU_SEQ_DIVZERO_TRAP_EN`:
- Defined: a DIV or MOD whose captured operand2 == 0 is suppressed at accept. The FSM stays in IDLE, `trap` pulses in the next cycle, `done` stays 0, and registers, `flags_q` and `cmp_q` are unchanged. Nothing is issued to the ALU.
- Undefined: `trap` is tied 0, and DIV/MOD by zero executes normally and writes whatever the ALU returns.

## Structure
Package `alu_seq_pkg` holds:
- The ALU select constants: `ALU_SEL_NOP`=8'd0, `ALU_SEL_ADD`=8'd11, `ALU_SEL_SUB`=8'd100, `ALU_SEL_DIV`=8'd110, `ALU_SEL_MOD`=8'd111, `ALU_SEL_CMP`=8'd24.
- The state enum.

Sub-module: `alu_seq_regfile`, with 1 write port, 2 synchronous-capture read ports and 1 combinational debug port.

## Test plan
1. Reset, then ADD dst=r1, src1=r0, imm=5 → r1=5, `done` 3 cycles after the accept edge, `alu_sel`=11 during ISSUE.
2. r1=5, r2=7 (loaded via imm), then ADD r3=r1+r2 → r3=12, `flags_q[0]`=0.
3. CMP src1=r1, src2=r2 → r1/r2/r3 unchanged, `cmp_q` equals the ALU `{lt,gt,eq}` sampled at the capture edge, `flags_q` updated.
4. DIV r1 by imm 0:
   - With the macro: `trap`=1 for one cycle, r1 stays 5, `done`=0.
   - Without the macro: `done` pulses and r1 ← the ALU result.
5. `cmd_valid` held continuously with two queued commands → the second is accepted exactly at E0+3, and `cmd_ready`=0 throughout ISSUE.
6. Assert `reset` in the 2nd ISSUE cycle of a write to r2 → r2=0, all state cleared, no `done` pulse.
